// File: rtl/vga_pixel_writer.sv
// vga_pixel_writer
// ----------------
// Takes the per-cycle pixel stream from the circle/clear controller and
// writes it into the single-port 160x120x3 framebuffer RAM. The scan-out
// reader owns the RAM port whenever it asks for it, so accepted pixels wait
// in a small FIFO. The controller has no ready input, so this block never
// applies backpressure: pixels that arrive while the FIFO is full are dropped
// and recorded in a sticky overflow flag.
//
// Configuration macro:
//   PIXEL_MERGE_EN - when defined, a pixel whose address matches the most
//                    recently buffered entry (still resident and not popped
//                    this cycle) overwrites that entry's colour instead of
//                    taking a new FIFO slot.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_x/in_y  pixel coordinates from the controller
//   in_colour  pixel colour from the controller
//   in_draw    pixel valid strobe, one pixel per cycle while high
//   scan_req   scan-out reader owns the RAM port this cycle
//   scan_addr  scan-out read address
//   ovf_clr    synchronous clear of the overflow flag
//   mem_addr   registered RAM address
//   mem_wdata  registered RAM write data
//   mem_we     registered RAM write enable
//   busy       FIFO non-empty or a write on the RAM port
//   overflow   sticky: a pixel was dropped on a full FIFO
//   clip_count saturating count of off-screen pixels
module vga_pixel_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_x,
    input  logic [6:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              in_draw,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              ovf_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        clip_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [ADDR_W-1:0]  fifo_addr_r [FIFO_DEPTH];
    logic [2:0]         fifo_col_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_r;
    logic [PTR_W-1:0]   rptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;

    logic [ADDR_W-1:0]  mem_addr_r;
    logic [2:0]         mem_wdata_r;
    logic               mem_we_r;
    logic               busy_r;
    logic               overflow_r;
    logic [7:0]         clip_count_r;

    logic               clipped_s;
    logic               valid_s;
    logic [ADDR_W-1:0]  pix_addr_s;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               merge_s;
    logic               drop_s;

    // Clipping, linear address and FIFO push/pop/merge/drop decisions.
    always_comb begin
        clipped_s  = (int'(in_x) >= H_RES) || (int'(in_y) >= V_RES);
        valid_s    = in_draw && !clipped_s;
        pix_addr_s = ADDR_W'(in_y) * ADDR_W'(H_RES) + ADDR_W'(in_x);
        empty_s    = (count_r == {CNT_W{1'b0}});
        full_s     = (count_r == CNT_W'(FIFO_DEPTH));
        // The scan-out reader always wins the port, so a pop only happens
        // in WRITE with the port free.
        pop_s      = (state_r == ST_WRITE) && !scan_req && !empty_s;
`ifdef PIXEL_MERGE_EN
        // The newest entry sits at wptr-1; it is only popped this cycle when
        // it is also the head, i.e. the FIFO holds exactly one entry.
        merge_s    = valid_s && !empty_s
                     && !(pop_s && (count_r == CNT_W'(1)))
                     && (fifo_addr_r[wptr_r - PTR_W'(1)] == pix_addr_s);
`else
        merge_s    = 1'b0;
`endif
        push_s     = valid_s && !merge_s && (!full_s || pop_s);
        drop_s     = valid_s && !merge_s && full_s && !pop_s;

        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // Next-state logic for the RAM port arbiter.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && scan_req) begin
                    state_s = ST_HOLD;
                end else if (!empty_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (scan_req) begin
                    state_s = ST_HOLD;
                end else if (empty_s || (pop_s && !push_s && (count_r == CNT_W'(1)))) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_HOLD: begin
                if (scan_req) begin
                    state_s = ST_HOLD;
                end else if (!empty_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            count_r <= count_s;
        end
    end

    // FIFO storage: new entries on push, colour overwrite on merge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_col_r[i]  <= 3'd0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wptr_r] <= pix_addr_s;
                fifo_col_r[wptr_r]  <= in_colour;
            end
`ifdef PIXEL_MERGE_EN
            else if (merge_s) begin
                fifo_col_r[wptr_r - PTR_W'(1)] <= in_colour;
            end
`endif
        end
    end

    // RAM port registers: popped pixel, else scan-out address with writes off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 3'd0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                mem_addr_r  <= fifo_addr_r[rptr_r];
                mem_wdata_r <= fifo_col_r[rptr_r];
                mem_we_r    <= 1'b1;
            end else if (scan_req) begin
                mem_addr_r  <= scan_addr;
                mem_we_r    <= 1'b0;
            end else begin
                mem_we_r    <= 1'b0;
            end
            // Registered image of "count > 0 or write on the port".
            busy_r <= (count_s != {CNT_W{1'b0}}) || pop_s;
        end
    end

    // Sticky overflow (a new drop beats a clear) and saturating clip counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r   <= 1'b0;
            clip_count_r <= 8'd0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
            if (in_draw && clipped_s && (clip_count_r != 8'd255)) begin
                clip_count_r <= clip_count_r + 8'd1;
            end
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign clip_count = clip_count_r;

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Testbench for vga_pixel_writer. Expected RAM writes are queued as pixels
// are driven; a monitor pops and compares them whenever mem_we is seen.
module tb_vga_pixel_writer;

    localparam int ADDR_W = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [2:0]        c;
    } pix_t;

    logic              clk;
    logic              rst;
    logic [7:0]        in_x;
    logic [6:0]        in_y;
    logic [2:0]        in_colour;
    logic              in_draw;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              ovf_clr;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_wdata;
    logic              mem_we;
    logic              busy;
    logic              overflow;
    logic [7:0]        clip_count;

    int   n_cmp;
    int   n_fail;
    pix_t exp_q[$];
    pix_t mon_e;

    vga_pixel_writer #(
        .H_RES(160), .V_RES(120), .ADDR_W(ADDR_W), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_draw(in_draw),
        .scan_req(scan_req), .scan_addr(scan_addr), .ovf_clr(ovf_clr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .overflow(overflow), .clip_count(clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every observed write must match the queue head.
    always @(posedge clk) begin
        #1;
        if (rst && mem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got write addr=%0d data=%0d, required no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== {mon_e.a, mon_e.c}) begin
                    n_fail++;
                    $display("FAIL wr_data: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             mem_addr, mem_wdata, mon_e.a, mon_e.c);
                end
            end
        end
    end

    // Drive one pixel for the coming edge.
    task automatic drive_pix(input int x, input int y, input int c);
        in_x      = 8'(x);
        in_y      = 7'(y);
        in_colour = 3'(c);
        in_draw   = 1'b1;
    endtask

    // Count writes over a bounded window of cycles.
    task automatic collect(input int cycles, output int nw, output int first, output int last);
        nw = 0; first = -1; last = -1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_draw = 1'b0;
            if (mem_we === 1'b1) begin
                nw++;
                if (first < 0) first = i;
                last = i;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_we, busy, overflow, clip_count} !== {15'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d wd=%0d we=%b busy=%b ovf=%b clip=%0d, required all zero",
                     mem_addr, mem_wdata, mem_we, busy, overflow, clip_count);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_pix(10, 5, 5);
        exp_q.push_back('{a: 15'd810, c: 3'd5});
        @(negedge clk);  // edge N taken
        in_draw = 1'b0;
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_n: got we=%b busy=%b, required we=0 busy=1", mem_we, busy);
        end
        @(negedge clk);  // N+1
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: got we=%b, required 0", mem_we);
        end
        @(negedge clk);  // N+2
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd810 || mem_wdata !== 3'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_n2: got we=%b addr=%0d wd=%0d busy=%b, required we=1 addr=810 wd=5 busy=1",
                     mem_we, mem_addr, mem_wdata, busy);
        end
        @(negedge clk);  // N+3
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_n3: got we=%b busy=%b pending=%0d, required 0 0 0", mem_we, busy, exp_q.size());
        end
    endtask

    task automatic test_clip();
        @(negedge clk); drive_pix(160, 0, 1);
        @(negedge clk); drive_pix(0, 123, 2);
        @(negedge clk); in_draw = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (clip_count !== 8'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_two: got clip=%0d busy=%b, required clip=2 busy=0", clip_count, busy);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i[0]) drive_pix(5, 120, 3);
            else      drive_pix(200, 7, 3);
        end
        @(negedge clk); in_draw = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (clip_count !== 8'd255 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_sat: got clip=%0d busy=%b, required clip=255 busy=0", clip_count, busy);
        end
        // Largest on-screen coordinate is still accepted.
        @(negedge clk); drive_pix(159, 119, 2);
        exp_q.push_back('{a: 15'd19199, c: 3'd2});
        @(negedge clk); in_draw = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || clip_count !== 8'd255 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_edge: got pending=%0d clip=%0d busy=%b, required 0 255 0",
                     exp_q.size(), clip_count, busy);
        end
    endtask

    task automatic test_scan_hold();
        logic [ADDR_W-1:0] sa_prev;
        int nw, first, last;
        sa_prev = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (mem_we !== 1'b0 || mem_addr !== sa_prev) begin
                    n_fail++;
                    $display("FAIL hold_track: got we=%b addr=%0d, required we=0 addr=%0d", mem_we, mem_addr, sa_prev);
                end
            end
            scan_req  = 1'b1;
            sa_prev   = 15'(1000 + i * 7);
            scan_addr = sa_prev;
            drive_pix(i, 1, i);
            if (i < 8) exp_q.push_back('{a: 15'(160 + i), c: 3'(i)});
        end
        @(negedge clk);
        in_draw = 1'b0;
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== sa_prev || overflow !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_full: got we=%b addr=%0d ovf=%b busy=%b, required we=0 addr=%0d ovf=1 busy=1",
                     mem_we, mem_addr, overflow, busy, sa_prev);
        end
        repeat (3) @(negedge clk);
        scan_req = 1'b0;
        collect(20, nw, first, last);
        n_cmp++;
        if (nw != 8 || (last - first) != 7 || exp_q.size() != 0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_drain: got writes=%0d span=%0d pending=%0d ovf=%b, required 8 7 0 1",
                     nw, last - first, exp_q.size(), overflow);
        end
    endtask

    task automatic test_ovf_clr();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b, required 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        int nw, first, last;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            scan_req = 1'b1;
            drive_pix(i, 2, i + 1);
            exp_q.push_back('{a: 15'(320 + i), c: 3'(i + 1)});
        end
        @(negedge clk);
        in_draw  = 1'b0;
        scan_req = 1'b0;
        nw = 0;
        // FIFO is full and draining; pushes coincide with pops.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) nw++;
            drive_pix(i, 3, i);
            exp_q.push_back('{a: 15'(480 + i), c: 3'(i)});
        end
        collect(20, last, first, first);
        nw = nw + last;
        n_cmp++;
        if (nw != 20 || exp_q.size() != 0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got writes=%0d pending=%0d ovf=%b busy=%b, required 20 0 0 0",
                     nw, exp_q.size(), overflow, busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        int nw, first, last;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            scan_req = 1'b1;
            drive_pix(40 + i, 9, i);
            if (i < 2) exp_q.push_back('{a: 15'(9 * 160 + 40 + i), c: 3'(i)});
        end
        @(negedge clk); in_draw = 1'b0; scan_req = 1'b0;  // HOLD -> WRITE
        @(negedge clk);                                   // first pop in flight
        @(negedge clk);                                   // write 0 on port
        @(negedge clk);                                   // write 1 on port
        n_cmp++;
        if (mem_we !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_pre: got we=%b pending=%0d, required we=1 pending=0", mem_we, exp_q.size());
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got we=%b busy=%b, required 0 0", mem_we, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        collect(15, nw, first, last);
        n_cmp++;
        if (nw != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got writes=%0d busy=%b, required 0 0", nw, busy);
        end
    endtask

    task automatic test_merge();
        int nw, first, last, want;
        @(negedge clk); scan_req = 1'b1; drive_pix(20, 20, 1);
        @(negedge clk); drive_pix(20, 20, 6);
`ifdef PIXEL_MERGE_EN
        exp_q.push_back('{a: 15'd3220, c: 3'd6});
        want = 1;
`else
        exp_q.push_back('{a: 15'd3220, c: 3'd1});
        exp_q.push_back('{a: 15'd3220, c: 3'd6});
        want = 2;
`endif
        @(negedge clk); in_draw = 1'b0;
        @(negedge clk); scan_req = 1'b0;
        collect(15, nw, first, last);
        n_cmp++;
        if (nw != want || exp_q.size() != 0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL merge: got writes=%0d pending=%0d ovf=%b, required %0d 0 0",
                     nw, exp_q.size(), overflow, want);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0; in_draw = 1'b0;
        scan_req = 1'b0; scan_addr = 15'd0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_clip();
        test_scan_hold();
        test_ovf_clr();
        test_back_to_back();
        test_reset_mid_drain();
        test_merge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
